// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state encoding, port indices and default widths for ram_arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_ADDR_W      = 8;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_RAM_LATENCY = 1;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - two-port grant selection; round-robin by default, fixed priority with ARB_FIXED_PRIO_EN
module arb_pick
    import ram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt
);

`ifdef ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;

    always_comb begin
        gnt_valid = req0 | req1;
        gnt       = req0 ? PORT0 : PORT1;
    end
`else
    // On a tie the port that was not served last wins.
    always_comb begin
        gnt_valid = req0 | req1;
        gnt       = PORT0;
        if (req0 && req1) begin
            gnt = ~last;
        end else if (req1) begin
            gnt = PORT1;
        end
    end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one single-port RAM between two requesters (ARB_FIXED_PRIO_EN selects fixed priority)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int RAM_LATENCY = DEF_RAM_LATENCY
) (
    input  logic              CLOCK_50,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

    state_t           state;
    state_t           state_nxt;
    logic             last;
    logic             cur;
    logic             lat_we;
    logic             gnt_valid;
    logic             gnt;
    logic [CNT_W-1:0] cnt;
    logic             last_wait;

    arb_pick u_pick (
        .req0      (req0),
        .req1      (req1),
        .last      (last),
        .gnt_valid (gnt_valid),
        .gnt       (gnt)
    );

    assign last_wait = (cnt == CNT_W'(RAM_LATENCY - 1));

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (last_wait) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ram_* are loaded on the IDLE->ISSUE edge so they are valid, registered, during ISSUE;
    // ack and rdata are loaded on the WAIT->ACK edge so they appear together in ACK.
    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            last     <= PORT1;
            cur      <= PORT0;
            lat_we   <= 1'b0;
            cnt      <= '0;
            ram_addr <= '0;
            ram_data <= '0;
            ram_wren <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            ram_wren <= 1'b0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        cur      <= gnt;
                        last     <= gnt;
                        lat_we   <= gnt ? we1 : we0;
                        ram_wren <= gnt ? we1 : we0;
                        ram_addr <= gnt ? addr1 : addr0;
                        ram_data <= gnt ? wdata1 : wdata0;
                    end
                end
                ISSUE: begin
                    cnt <= '0;
                end
                WAIT: begin
                    if (!last_wait) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        if (!lat_we && cur == PORT0) rdata0 <= ram_q;
                        if (!lat_we && cur == PORT1) rdata1 <= ram_q;
                        ack0 <= (cur == PORT0);
                        ack1 <= (cur == PORT1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed self-checking bench for ram_arbiter with a latency-1 RAM model
module tb_ram_arbiter;

    logic       CLOCK_50 = 1'b0;
    logic       Reset;
    logic       req0, req1, we0, we1;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       ack0, ack1;
    logic [7:0] rdata0, rdata1;
    logic [7:0] ram_addr, ram_data;
    logic       ram_wren;
    logic [7:0] ram_q;
    logic       preload;
    logic [7:0] mem [256];

    int checks = 0;
    int errors = 0;

    ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RAM_LATENCY(1)) dut (
        .CLOCK_50 (CLOCK_50),
        .Reset    (Reset),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .ack0     (ack0),
        .ack1     (ack1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_wren (ram_wren),
        .ram_q    (ram_q)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(posedge CLOCK_50) begin
        if (preload) begin
            mem[8'h05] <= 8'hA3;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic e0, e1;
        Reset = 1'b1; preload = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        tick();
        preload = 1'b0;
        tick();
        check("rst_ack0", ack0, 0);
        check("rst_ack1", ack1, 0);
        check("rst_wren", ram_wren, 0);
        check("rst_addr", ram_addr, 0);
        check("rst_data", ram_data, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_rdata1", rdata1, 0);

        // read latency: port 0 reads 0x05
        Reset = 0; req0 = 1; we0 = 0; addr0 = 8'h05;
        tick();
        check("rd_c1_addr", ram_addr, 8'h05);
        check("rd_c1_wren", ram_wren, 0);
        check("rd_c1_ack0", ack0, 0);
        tick();
        check("rd_c2_ack0", ack0, 0);
        check("rd_c2_wren", ram_wren, 0);
        tick();
        check("rd_c3_ack0", ack0, 1);
        check("rd_c3_ack1", ack1, 0);
        check("rd_c3_rdata0", rdata0, 8'hA3);
        req0 = 0;
        tick();
        check("rd_c4_ack0", ack0, 0);

        // write on port 1 then read back on port 0
        req1 = 1; we1 = 1; addr1 = 8'h10; wdata1 = 8'h5C;
        tick();
        check("wr_c1_wren", ram_wren, 1);
        check("wr_c1_addr", ram_addr, 8'h10);
        check("wr_c1_data", ram_data, 8'h5C);
        tick();
        check("wr_c2_wren", ram_wren, 0);
        tick();
        check("wr_c3_ack1", ack1, 1);
        check("wr_c3_ack0", ack0, 0);
        check("wr_c3_rdata1", rdata1, 0);
        req1 = 0; we1 = 0;
        tick();
        req0 = 1; we0 = 0; addr0 = 8'h10;
        tick();
        check("rb_c1_wren", ram_wren, 0);
        tick();
        tick();
        check("rb_c3_ack0", ack0, 1);
        check("rb_c3_rdata0", rdata0, 8'h5C);
        req0 = 0;
        tick();

        // dropped request: req0 removed in cycle 1, ack still arrives, nothing re-issued
        req0 = 1; addr0 = 8'h05;
        tick();
        req0 = 0;
        tick();
        tick();
        check("drop_c3_ack0", ack0, 1);
        check("drop_c3_rdata0", rdata0, 8'hA3);
        for (int k = 4; k <= 9; k++) begin
            tick();
            check($sformatf("drop_c%0d_ack0", k), ack0, 0);
            check($sformatf("drop_c%0d_wren", k), ram_wren, 0);
        end

        // reset during WAIT of a port-1 read
        req1 = 1; we1 = 0; addr1 = 8'h05;
        tick();
        check("mid_c1_addr", ram_addr, 8'h05);
        tick();
        Reset = 1; req1 = 0;
        tick();
        check("mid_ack1", ack1, 0);
        check("mid_ack0", ack0, 0);
        check("mid_rdata0", rdata0, 0);
        check("mid_rdata1", rdata1, 0);
        check("mid_addr", ram_addr, 0);
        check("mid_data", ram_data, 0);
        check("mid_wren", ram_wren, 0);
        tick();
        check("mid_hold_ack1", ack1, 0);

        // both ports saturated from reset
        Reset = 0;
        req0 = 1; we0 = 0; addr0 = 8'h05;
        req1 = 1; we1 = 0; addr1 = 8'h10;
        for (int k = 1; k <= 32; k++) begin
            tick();
            e0 = 1'b0;
            e1 = 1'b0;
            if (k % 4 == 3) begin
`ifdef ARB_FIXED_PRIO_EN
                e0 = 1'b1;
`else
                if ((k / 4) % 2 == 0) e0 = 1'b1;
                else e1 = 1'b1;
`endif
            end
            check($sformatf("sat_c%0d_ack0", k), ack0, e0);
            check($sformatf("sat_c%0d_ack1", k), ack1, e1);
            if (e0) check($sformatf("sat_c%0d_rdata0", k), rdata0, 8'hA3);
            if (e1) check($sformatf("sat_c%0d_rdata1", k), rdata1, 8'h5C);
        end
        req0 = 0; req1 = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
